// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a one-word holding buffer; first bit appears the cycle after accept.
// in_ready drops only while the holding buffer is full, so back-to-back words stream with no idle bit.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             serial_out,
  output logic             out_valid,
  output logic             first_bit,
  output logic             last_bit,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_q, shift_nxt;
  logic [WIDTH-1:0] hold_q, hold_nxt;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic             hold_full, hold_full_nxt;
  logic             xfer;
  logic             at_last;
  logic [WIDTH-1:0] shifted;

  assign in_ready = rst & ~hold_full;
  assign xfer     = in_valid & in_ready;
  assign at_last  = (state == SHIFT) && (bit_cnt == LAST_CNT);
  assign shifted  = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift_q   <= '0;
      hold_q    <= '0;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_q   <= shift_nxt;
      hold_q    <= hold_nxt;
      bit_cnt   <= bit_cnt_nxt;
      hold_full <= hold_full_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift_q;
    hold_nxt      = hold_q;
    bit_cnt_nxt   = bit_cnt;
    hold_full_nxt = hold_full;
    case (state)
      IDLE: begin
        if (xfer) begin
          shift_nxt   = parallel_in;
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (at_last) begin
          // Held word has priority; in_ready is already low when it exists.
          bit_cnt_nxt = '0;
          if (hold_full) begin
            shift_nxt     = hold_q;
            hold_full_nxt = 1'b0;
          end else if (xfer) begin
            shift_nxt = parallel_in;
          end else begin
            shift_nxt = shifted;
            state_nxt = IDLE;
          end
        end else begin
          shift_nxt   = shifted;
          bit_cnt_nxt = bit_cnt + CW'(1);
          if (xfer) begin
            hold_nxt      = parallel_in;
            hold_full_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid  = (state == SHIFT);
  assign serial_out = out_valid & (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
  assign first_bit  = out_valid & (bit_cnt == '0);
  assign last_bit   = at_last;
  assign busy       = out_valid | hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (4-bit MSB-first, 4-bit LSB-first, 8-bit MSB-first)
// checked against per-instance queues of expected {bit, first, last} tuples.
module tb_piso_serializer;

  logic clk;
  logic rst;

  logic [3:0] d0_pin;
  logic       d0_vld, d0_rdy, d0_so, d0_ov, d0_fb, d0_lb, d0_busy;
  logic [3:0] d1_pin;
  logic       d1_vld, d1_rdy, d1_so, d1_ov, d1_fb, d1_lb, d1_busy;
  logic [7:0] d2_pin;
  logic       d2_vld, d2_rdy, d2_so, d2_ov, d2_fb, d2_lb, d2_busy;

  int total = 0;
  int bad   = 0;
  int waits = 0;
  int run[3];
  int last_run[3];

  logic [2:0] q0[$];
  logic [2:0] q1[$];
  logic [2:0] q2[$];

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .parallel_in(d0_pin), .in_valid(d0_vld), .in_ready(d0_rdy),
    .serial_out(d0_so), .out_valid(d0_ov), .first_bit(d0_fb), .last_bit(d0_lb), .busy(d0_busy)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .parallel_in(d1_pin), .in_valid(d1_vld), .in_ready(d1_rdy),
    .serial_out(d1_so), .out_valid(d1_ov), .first_bit(d1_fb), .last_bit(d1_lb), .busy(d1_busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut2 (
    .clk(clk), .rst(rst), .parallel_in(d2_pin), .in_valid(d2_vld), .in_ready(d2_rdy),
    .serial_out(d2_so), .out_valid(d2_ov), .first_bit(d2_fb), .last_bit(d2_lb), .busy(d2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [2:0] e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pop_exp(input int id, output logic [2:0] e);
    case (id)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // Scoreboard side: every valid bit must match the head of that instance's queue.
  task automatic mon(input int id, input logic ov, input logic so, input logic fb,
                     input logic lb, input logic bz);
    logic [2:0] e;
    if (ov) begin
      run[id]++;
      chk($sformatf("busy_with_valid[%0d]", id), bz, 1);
      if (qsize(id) == 0) begin
        chk($sformatf("unexpected_bit[%0d]", id), ov, 0);
      end else begin
        pop_exp(id, e);
        chk($sformatf("serial_bit[%0d]", id), so, e[2]);
        chk($sformatf("first_bit[%0d]", id), fb, e[1]);
        chk($sformatf("last_bit[%0d]", id), lb, e[0]);
      end
    end else begin
      if (run[id] != 0) begin
        last_run[id] = run[id];
        run[id] = 0;
      end
      chk($sformatf("idle_quiet[%0d]", id), {29'd0, so, fb, lb}, 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, d0_ov, d0_so, d0_fb, d0_lb, d0_busy);
    mon(1, d1_ov, d1_so, d1_fb, d1_lb, d1_busy);
    mon(2, d2_ov, d2_so, d2_fb, d2_lb, d2_busy);
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int id, input logic [7:0] w);
    int   wd;
    bit   msb;
    bit   accepted;
    logic rdy;
    logic b;
    wd  = (id == 2) ? 8 : 4;
    msb = (id != 1);
    case (id)
      0:       begin d0_pin = w[3:0]; d0_vld = 1'b1; end
      1:       begin d1_pin = w[3:0]; d1_vld = 1'b1; end
      default: begin d2_pin = w;      d2_vld = 1'b1; end
    endcase
    for (int i = 0; i < wd; i++) begin
      b = msb ? w[wd-1-i] : w[i];
      push_exp(id, {b, (i == 0), (i == wd - 1)});
    end
    accepted = 1'b0;
    for (int i = 0; i < 40 && !accepted; i++) begin
      @(negedge clk);
      rdy = (id == 0) ? d0_rdy : (id == 1) ? d1_rdy : d2_rdy;
      if (!rdy) waits++;
      @(posedge clk);
      #1;
      if (rdy) accepted = 1'b1;
    end
    chk($sformatf("accept_timeout[%0d]", id), {31'd0, accepted}, 1);
  endtask

  task automatic drop(input int id);
    case (id)
      0:       d0_vld = 1'b0;
      1:       d1_vld = 1'b0;
      default: d2_vld = 1'b0;
    endcase
  endtask

  task automatic drain(input int id);
    bit   done;
    logic bz;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      bz = (id == 0) ? d0_busy : (id == 1) ? d1_busy : d2_busy;
      if (!bz && qsize(id) == 0) done = 1'b1;
    end
    chk($sformatf("drain_timeout[%0d]", id), {31'd0, done}, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    d0_pin = '0; d0_vld = 1'b0;
    d1_pin = '0; d1_vld = 1'b0;
    d2_pin = '0; d2_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run[i] = 0;
      last_run[i] = 0;
    end

    // Reset state
    #12;
    chk("rst_outputs", {26'd0, d0_rdy, d0_so, d0_ov, d0_fb, d0_lb, d0_busy}, 0);
    chk("rst_in_ready_w8", d2_rdy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", d0_rdy, 1);
    chk("post_rst_busy", d0_busy, 0);
    @(posedge clk); #1;

    // Single word 1011, one-cycle valid
    send(0, 8'b1011);
    drop(0);
    chk("busy_after_accept", d0_busy, 1);
    @(negedge clk);
    chk("first_latency_valid", d0_ov, 1);
    chk("first_latency_strobe", d0_fb, 1);
    drain(0);
    chk("run_single", last_run[0], 4);
    chk("idle_after_single", {30'd0, d0_ov, d0_busy}, 0);

    // Two words on consecutive cycles stream contiguously
    send(0, 8'b1011);
    send(0, 8'b1111);
    drop(0);
    chk("hold_rdy_low_a", d0_rdy, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hold_rdy_low_b", d0_rdy, 0);
    @(posedge clk); #1;
    chk("hold_rdy_released", d0_rdy, 1);
    drain(0);
    chk("run_two_words", last_run[0], 8);

    // Three words with valid held high: backpressure, no drop or repeat
    waits = 0;
    send(0, 8'b0001);
    send(0, 8'b1000);
    send(0, 8'b0101);
    drop(0);
    chk("backpressure_waits", waits, 3);
    drain(0);
    chk("run_three_words", last_run[0], 12);

    // LSB-first word 0001 -> 1,0,0,0
    send(1, 8'b0001);
    drop(1);
    drain(1);
    chk("run_lsb_first", last_run[1], 4);

    // 8-bit word A5
    send(2, 8'hA5);
    drop(2);
    drain(2);
    chk("run_w8", last_run[2], 8);

    // Asynchronous reset mid-word with a word in hold
    send(0, 8'b0011);
    send(0, 8'b1110);
    drop(0);
    chk("pre_abort_busy", d0_busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_outputs", {26'd0, d0_rdy, d0_so, d0_ov, d0_fb, d0_lb, d0_busy}, 0);
    q0.delete();
    @(posedge clk); #1;
    chk("abort_held_busy", d0_busy, 0);
    rst = 1'b1;
    #1;
    chk("abort_release_rdy", d0_rdy, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_residual", d0_ov, 0);
    end
    @(posedge clk); #1;
    send(0, 8'b0101);
    drop(0);
    drain(0);
    chk("run_after_abort", last_run[0], 4);

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
